// File: rtl/ysyx_23060203_pkg.sv
// Shared encodings for the RV32M multiply/divide unit.
package ysyx_23060203_pkg;

  // RV32M funct3 encoding
  typedef enum logic [2:0] {
    F_MUL    = 3'b000,
    F_MULH   = 3'b001,
    F_MULHSU = 3'b010,
    F_MULHU  = 3'b011,
    F_DIV    = 3'b100,
    F_DIVU   = 3'b101,
    F_REM    = 3'b110,
    F_REMU   = 3'b111
  } funct_e;

  // Control FSM states
  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_e;

  // rs1 is treated as signed for MUL/MULH/MULHSU/DIV/REM
  function automatic logic rs1_signed(input logic [2:0] f);
    return f[2] ? ~f[0] : (f[1:0] != 2'b11);
  endfunction

  // rs2 is treated as signed for MUL/MULH/DIV/REM
  function automatic logic rs2_signed(input logic [2:0] f);
    return f[2] ? ~f[0] : ~f[1];
  endfunction

endpackage

// File: rtl/ysyx_23060203_mdu.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// sign fix-up on the final iteration edge, valid/ready result handshake.
module ysyx_23060203_mdu
  import ysyx_23060203_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MUL_BITS = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [XLEN-1:0] out_val,
  output logic            busy
);

  localparam int unsigned CNT_W     = $clog2(XLEN) + 1;
  localparam int unsigned MUL_ITERS = XLEN / MUL_BITS;
  localparam int unsigned PW        = 2 * XLEN;

  state_e            state, next_state;
  logic [CNT_W-1:0]  cnt;
  funct_e            funct;
  logic              neg_q;   // negate product / quotient
  logic              neg_r;   // negate remainder
  logic [PW-1:0]     acc;     // product accumulator
  logic [PW-1:0]     mcand;   // shifted multiplicand
  logic [XLEN-1:0]   shreg;   // multiplier (MUL) or dividend->quotient (DIV)
  logic [XLEN-1:0]   dvsr;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   res;

  logic              accept, last, handshake;
  logic              a_neg, b_neg, div_zero, div_ovf, special;
  logic [XLEN-1:0]   a_mag, b_mag, special_res;
  logic [PW-1:0]     partial, acc_nxt, mul_fix;
  logic [XLEN:0]     shifted, diff;
  logic              ge;
  logic [XLEN-1:0]   rem_nxt, quo_nxt, mul_res, div_res;

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_DONE) & ~flush;
  assign out_val   = res;
  assign accept    = in_valid & in_ready & ~flush;
  assign handshake = out_valid & out_ready;
  assign last      = (cnt == CNT_W'(1));

  // Request decode: operand magnitudes and divide special cases
  always_comb begin
    a_neg       = rs1_signed(in_funct) & in_a[XLEN-1];
    b_neg       = rs2_signed(in_funct) & in_b[XLEN-1];
    a_mag       = a_neg ? -in_a : in_a;
    b_mag       = b_neg ? -in_b : in_b;
    div_zero    = (in_b == '0);
    div_ovf     = ~in_funct[0] & (in_a == {1'b1, {(XLEN-1){1'b0}}}) & (&in_b);
    special     = in_funct[2] & (div_zero | div_ovf);
    special_res = '0;
    if (div_zero) special_res = in_funct[1] ? in_a : '1;
    else          special_res = in_funct[1] ? '0 : in_a;
  end

  // One multiply step and one restoring-divide step, plus sign fix-up
  always_comb begin
    partial = '0;
    for (int unsigned i = 0; i < MUL_BITS; i++) begin
      if (shreg[i]) partial = partial + (mcand << i);
    end
    acc_nxt = acc + partial;
    mul_fix = neg_q ? -acc_nxt : acc_nxt;
    mul_res = (funct == F_MUL) ? mul_fix[XLEN-1:0] : mul_fix[PW-1:XLEN];

    shifted = {rem, shreg[XLEN-1]};
    ge      = (shifted >= {1'b0, dvsr});
    diff    = shifted - {1'b0, dvsr};
    rem_nxt = XLEN'(ge ? diff : shifted);
    quo_nxt = {shreg[XLEN-2:0], ge};
    if (funct[1]) div_res = neg_r ? -rem_nxt : rem_nxt;
    else          div_res = neg_q ? -quo_nxt : quo_nxt;
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state logic; flush overrides everything
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (!in_funct[2]) next_state = S_MUL;
          else if (special) next_state = S_DONE;
          else              next_state = S_DIV;
        end
      end
      S_MUL, S_DIV: if (last) next_state = S_DONE;
      S_DONE:       if (handshake) next_state = S_IDLE;
      default:      next_state = S_IDLE;
    endcase
    if (flush) next_state = S_IDLE;
  end

  // Iteration counter
  always_ff @(posedge clock) begin
    if (reset)
      cnt <= '0;
    else if (accept)
      cnt <= in_funct[2] ? CNT_W'(XLEN) : CNT_W'(MUL_ITERS);
    else if ((state == S_MUL || state == S_DIV) && cnt != '0)
      cnt <= cnt - CNT_W'(1);
  end

  // Datapath registers: load on accept, iterate while busy, latch result on last step
  always_ff @(posedge clock) begin
    if (accept) begin
      funct <= funct_e'(in_funct);
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
      acc   <= '0;
      mcand <= PW'(a_mag);
      shreg <= in_funct[2] ? a_mag : b_mag;
      dvsr  <= b_mag;
      rem   <= '0;
      res   <= special_res;
    end else if (state == S_MUL) begin
      acc   <= acc_nxt;
      mcand <= mcand << MUL_BITS;
      shreg <= shreg >> MUL_BITS;
      if (last) res <= mul_res;
    end else if (state == S_DIV) begin
      rem   <= rem_nxt;
      shreg <= quo_nxt;
      if (last) res <= div_res;
    end
  end

endmodule

// File: doc/ysyx_23060203_mdu.md
YSYX_23060203_MDU -- requirements
Module: ysyx_23060203_MDU

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving the operand and result width (even, >= 8).
REQ-002 SHALL have parameter MUL_BITS, default 1, giving the multiplier bits retired per cycle (1, 2 or 4; divides XLEN).
REQ-003 SHALL have port clock  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port flush  in  1  aborts any in-flight operation.
REQ-006 SHALL have port in_valid  in  1  upstream request valid.
REQ-007 SHALL have port in_ready  out  1  unit can accept a request.
REQ-008 SHALL have port in_funct  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-009 SHALL have port in_a  in  XLEN  rs1 operand.
REQ-010 SHALL have port in_b  in  XLEN  rs2 operand.
REQ-011 SHALL have port out_ready  in  1  downstream can take the result.
REQ-012 SHALL have port out_valid  out  1  result valid.
REQ-013 SHALL have port out_val  out  XLEN  result.
REQ-014 SHALL have port busy  out  1  high in every state except IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, MUL, DIV, DONE; in_ready = (state==IDLE).
REQ-016 SHALL accept a request on an edge where in_valid & in_ready & ~flush, latching funct and operands; with flush high, the request SHALL be dropped.
REQ-017 On accept, funct[2]=0 SHALL go to MUL; DIV/DIVU/REM/REMU with in_b==0 or the signed-overflow case SHALL go straight to DONE; other divides SHALL go to DIV.
REQ-018 MUL SHALL be iterative shift-add on |operand| magnitudes (signedness per funct), retiring MUL_BITS per cycle, and SHALL stay XLEN/MUL_BITS cycles before entering DONE.
REQ-019 DIV SHALL be restoring division on magnitudes, 1 quotient bit per cycle, and SHALL stay XLEN cycles before entering DONE.
REQ-020 The final sign fix-up SHALL be applied on the DIV/MUL->DONE edge: product negated if operand signs differ; quotient negated if signs differ; remainder takes the dividend sign.
REQ-021 The result SHALL be selected as MUL = product[XLEN-1:0], MULH/MULHSU/MULHU = product[2*XLEN-1:XLEN], DIV/DIVU = quotient, REM/REMU = remainder.
REQ-022 Divide by zero SHALL return quotient all-ones and remainder = in_a, for signed and unsigned alike.
REQ-023 Signed overflow (in_a = 100..0, in_b = all-ones) SHALL return quotient = in_a and remainder = 0.
REQ-024 out_valid SHALL = (state==DONE) & ~flush; out_val SHALL stay stable while DONE.
REQ-025 DONE SHALL be held until out_ready & out_valid, then go to IDLE.
REQ-026 Latency from the accept edge to the first out_valid cycle SHALL be XLEN/MUL_BITS+1 cycles for MUL, XLEN+1 for DIV, and 1 for the special cases.
REQ-027 Flush in any state SHALL force IDLE on that edge, discard the result, and suppress out_valid in the same cycle.
REQ-028 A new request SHALL be accepted in the cycle following a flush or a completed handshake; no back-to-back accept in the handshake cycle.

Reset
REQ-029 Reset SHALL force state IDLE and clear the iteration counter; afterwards out_valid=0, busy=0, in_ready=1.
REQ-030 Reset mid-operation SHALL abandon the operation with no output; datapath registers need no reset.
REQ-031 out_val SHALL be don't-care while out_valid=0.

Structure
REQ-032 The funct3 encoding enum and the FSM state enum SHALL live in shared package ysyx_23060203_pkg.
REQ-033 The unit SHALL be a single module with no sub-module; the counter width SHALL be $clog2(XLEN)+1.

Verification (XLEN=32, MUL_BITS=1 unless stated)
REQ-034 MUL 7 x 0xFFFFFFFD -> out_val 0xFFFFFFEB, out_valid first in cycle 33 after accept.
REQ-035 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF; repeat with MUL_BITS=4 -> same values, latency 9.
REQ-036 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF; latency 33.
REQ-037 DIVU 5 / 0 -> 0xFFFFFFFF and REM 5 / 0 -> 5, each with latency 1; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-038 Flush 10 cycles into a DIV -> out_valid never asserts, in_ready=1 next cycle; a following DIVU 100 / 7 -> 14.
REQ-039 out_ready held low 5 cycles in DONE -> out_valid and out_val stable throughout, one handshake only, then IDLE.
